adder: RTL and testbench
========================

ADDER -- requirements
Module: adder

Interface
REQ-001 Parameter N (positional first parameter), default 32, meaning operand/result width in bits; the block SHALL support any N >= 1.
REQ-002 clk  input  1  single clock; all registered outputs update on its rising edge only.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 a  input  N  operand A, unsigned or two's-complement.
REQ-005 b  input  N  operand B, unsigned or two's-complement.
REQ-006 in_valid  input  1  qualifies a/b for capture into the registered result stage.
REQ-007 s  output  N  combinational sum.
REQ-008 cout  output  1  combinational unsigned carry-out of a+b.
REQ-009 ovf  output  1  combinational signed overflow of a+b.
REQ-010 s_q  output  N  registered sum.
REQ-011 cout_q, ovf_q, zero_q  output  1 each  registered carry, overflow and zero flags.
REQ-012 out_valid  output  1  registered; high when s_q and the registered flags hold a fresh result.

Function
REQ-013 s SHALL equal (a + b) mod 2^N, purely combinational, zero-cycle latency, independent of clk, rst and in_valid.
REQ-014 cout SHALL equal bit N of the (N+1)-bit unsigned sum a + b.
REQ-015 ovf SHALL be 1 iff a[N-1] == b[N-1] and s[N-1] != a[N-1].
REQ-016 Wrap-around: results SHALL truncate silently to N bits; no saturation.
REQ-017 The combinational outputs SHALL show no latched state and no X for known inputs, including while rst is high.
REQ-018 On a rising clk edge with rst=0 and in_valid=1, s_q, cout_q and ovf_q SHALL load s, cout and ovf, zero_q SHALL load (s == 0), and out_valid SHALL become 1; latency is 1 cycle.
REQ-019 On a rising clk edge with rst=0 and in_valid=0, s_q and the registered flags SHALL hold their values and out_valid SHALL become 0.
REQ-020 Back-to-back valid inputs SHALL be accepted every cycle; there is no backpressure and no stall.
REQ-021 The inputs SHALL be sampled only at the rising clk edge; changes between edges SHALL affect only the combinational outputs.

Reset
REQ-022 On a rising clk edge with rst=1: s_q=0, cout_q=0, ovf_q=0, zero_q=0, out_valid=0.
REQ-023 rst SHALL take priority over in_valid on the same edge; the input presented on that edge SHALL be discarded.
REQ-024 Reset asserted mid-stream SHALL discard any pending registered result; after rst falls, the first edge with in_valid=1 SHALL produce a valid result one cycle later.
REQ-025 After reset the block SHALL need no initialisation cycles.

Verification
REQ-026 a=0x00000000, b=0x00000004 -> s=0x00000004, cout=0, ovf=0 with no clock edge required.
REQ-027 a=0x00000004, b=0x00000004 -> s=0x00000008; then a=0x00000004, b=0x0000F004 -> s=0x0000F008.
REQ-028 a=0xFFFFFFFE, b=0x00000001 -> s=0xFFFFFFFF, cout=0, ovf=0; a=0xFFFFFFFF, b=0x00000001 -> s=0x00000000, cout=1, ovf=0.
REQ-029 a=0x7FFFFFFF, b=0x00000001 -> s=0x80000000, ovf=1, cout=0.
REQ-030 Registered path: rst=1 for 1 edge -> all registered outputs 0; then in_valid=1, a=0xFFFFFFFF, b=0x00000001 -> next edge s_q=0, zero_q=1, cout_q=1, out_valid=1; in_valid=0 -> next edge out_valid=0, s_q held.
REQ-031 Reset priority: rst=1 and in_valid=1 on the same edge -> out_valid=0 and s_q=0 after that edge.

Source files
------------

// File: rtl/adder.sv
// N-bit adder: combinational sum/carry/overflow plus a registered result stage with zero flag.
// Combinational outputs have zero latency; the registered stage loads one cycle after in_valid.
// No backpressure: a new operand pair may be accepted on every clock edge.
module adder #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         in_valid,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         ovf,
  output logic [N-1:0] s_q,
  output logic         cout_q,
  output logic         ovf_q,
  output logic         zero_q,
  output logic         out_valid
);

  logic [N:0] sum_ext;

  // One extra bit so the unsigned carry falls out of the same addition.
  assign sum_ext = {1'b0, a} + {1'b0, b};
  assign s       = sum_ext[N-1:0];
  assign cout    = sum_ext[N];
  assign ovf     = (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q       <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      // Result registers hold across idle cycles; only out_valid drops.
      if (in_valid) begin
        s_q    <= s;
        cout_q <= cout;
        ovf_q  <= ovf;
        zero_q <= (s == '0);
      end
    end
  end

endmodule

// File: tb/tb_adder.sv
// Directed self-checking bench for adder: combinational vectors, registered path, reset priority.
module tb_adder;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        in_valid;
  logic [31:0] s;
  logic        cout;
  logic        ovf;
  logic [31:0] s_q;
  logic        cout_q;
  logic        ovf_q;
  logic        zero_q;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

  adder #(.N(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .in_valid (in_valid),
    .s        (s),
    .cout     (cout),
    .ovf      (ovf),
    .s_q      (s_q),
    .cout_q   (cout_q),
    .ovf_q    (ovf_q),
    .zero_q   (zero_q),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = 32'h0000_0000; b = 32'h0000_0004;
    #1;
    // Combinational path works without any clock edge, even under reset.
    chk("comb0_s",    s,    32'h0000_0004);
    chk("comb0_cout", {31'b0, cout}, 32'd0);
    chk("comb0_ovf",  {31'b0, ovf},  32'd0);

    a = 32'h0000_0004; b = 32'h0000_0004; #1;
    chk("comb1_s", s, 32'h0000_0008);
    b = 32'h0000_F004; #1;
    chk("comb2_s", s, 32'h0000_F008);

    a = 32'hFFFF_FFFE; b = 32'h0000_0001; #1;
    chk("comb3_s",    s, 32'hFFFF_FFFF);
    chk("comb3_cout", {31'b0, cout}, 32'd0);
    chk("comb3_ovf",  {31'b0, ovf},  32'd0);

    a = 32'hFFFF_FFFF; b = 32'h0000_0001; #1;
    chk("comb4_s",    s, 32'h0000_0000);
    chk("comb4_cout", {31'b0, cout}, 32'd1);
    chk("comb4_ovf",  {31'b0, ovf},  32'd0);

    a = 32'h7FFF_FFFF; b = 32'h0000_0001; #1;
    chk("comb5_s",    s, 32'h8000_0000);
    chk("comb5_cout", {31'b0, cout}, 32'd0);
    chk("comb5_ovf",  {31'b0, ovf},  32'd1);

    // Negative + negative overflowing to positive.
    a = 32'h8000_0000; b = 32'h8000_0000; #1;
    chk("comb6_s",    s, 32'h0000_0000);
    chk("comb6_cout", {31'b0, cout}, 32'd1);
    chk("comb6_ovf",  {31'b0, ovf},  32'd1);

    tick();
    chk("rst_s_q",       s_q, 32'd0);
    chk("rst_cout_q",    {31'b0, cout_q},    32'd0);
    chk("rst_ovf_q",     {31'b0, ovf_q},     32'd0);
    chk("rst_zero_q",    {31'b0, zero_q},    32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);

    rst = 1'b0; in_valid = 1'b1; a = 32'hFFFF_FFFF; b = 32'h0000_0001;
    tick();
    chk("r1_s_q",       s_q, 32'h0000_0000);
    chk("r1_zero_q",    {31'b0, zero_q},    32'd1);
    chk("r1_cout_q",    {31'b0, cout_q},    32'd1);
    chk("r1_ovf_q",     {31'b0, ovf_q},     32'd0);
    chk("r1_out_valid", {31'b0, out_valid}, 32'd1);

    in_valid = 1'b0; a = 32'h0000_0005; b = 32'h0000_0006;
    tick();
    chk("idle_out_valid", {31'b0, out_valid}, 32'd0);
    chk("idle_s_q_held",  s_q, 32'h0000_0000);
    chk("idle_zero_held", {31'b0, zero_q}, 32'd1);
    chk("idle_cout_held", {31'b0, cout_q}, 32'd1);

    // Back-to-back accepts.
    in_valid = 1'b1; a = 32'h7FFF_FFFF; b = 32'h0000_0001;
    tick();
    chk("b2b0_s_q",       s_q, 32'h8000_0000);
    chk("b2b0_ovf_q",     {31'b0, ovf_q},  32'd1);
    chk("b2b0_cout_q",    {31'b0, cout_q}, 32'd0);
    chk("b2b0_zero_q",    {31'b0, zero_q}, 32'd0);
    chk("b2b0_out_valid", {31'b0, out_valid}, 32'd1);
    a = 32'h0000_0003; b = 32'h0000_0004;
    tick();
    chk("b2b1_s_q",       s_q, 32'h0000_0007);
    chk("b2b1_ovf_q",     {31'b0, ovf_q}, 32'd0);
    chk("b2b1_out_valid", {31'b0, out_valid}, 32'd1);

    // Between-edge input change moves only the combinational outputs.
    a = 32'h0000_0010; b = 32'h0000_0020; #2;
    chk("mid_s",   s,   32'h0000_0030);
    chk("mid_s_q", s_q, 32'h0000_0007);

    // Reset wins over in_valid on the same edge.
    rst = 1'b1; in_valid = 1'b1; a = 32'h0000_0001; b = 32'h0000_0001;
    tick();
    chk("prio_out_valid", {31'b0, out_valid}, 32'd0);
    chk("prio_s_q",       s_q, 32'd0);
    chk("prio_zero_q",    {31'b0, zero_q}, 32'd0);

    rst = 1'b0; in_valid = 1'b1; a = 32'h0000_0002; b = 32'h0000_0003;
    tick();
    chk("post_rst_s_q",       s_q, 32'h0000_0005);
    chk("post_rst_out_valid", {31'b0, out_valid}, 32'd1);

    in_valid = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
